// File: rtl/htif_pkg.sv
// rtl/htif_pkg.sv - shared constants and state types for the HTIF mailbox monitor
package htif_pkg;

  localparam logic [31:0] HTIF_CMD_EXIT = 32'h0000_0000;
  localparam logic [31:0] HTIF_CMD_PUTC = 32'h0101_0000;

  typedef enum logic [1:0] {
    END_NONE    = 2'd0,
    END_EXIT    = 2'd1,
    END_TIMEOUT = 2'd2
  } end_cause_e;

  typedef enum logic [1:0] {
    CH_EMPTY,
    CH_HAVE_ARG,
    CH_PEND
  } chan_st_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_EXEC,
    D_CLR_ARG,
    D_CLR_CMD
  } disp_st_e;

endpackage

// File: rtl/htif_char_fifo.sv
// rtl/htif_char_fifo.sv - show-ahead character FIFO with full/empty flags
module htif_char_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop    = pop && !empty;
  // A push into a full FIFO still lands when the head leaves the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr[PW-1:0]];

  // Pointer update; pointers wrap naturally at 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/htif_mbox_mon.sv
// rtl/htif_mbox_mon.sv - tohost mailbox snooper, dispatcher, end-of-test and watchdog
module htif_mbox_mon
  import htif_pkg::*;
#(
  parameter int             NCH         = 2,
  parameter int             AW          = 14,
  parameter int             DW          = 32,
  parameter logic [AW-1:0]  TOHOST_BASE = 'h400,
  parameter int             FIFO_DEPTH  = 8,
  parameter int             TIMEOUT     = 200000,
  localparam int            CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          snoop_cs,
  input  logic          snoop_we,
  input  logic [AW-1:0] snoop_a,
  input  logic [DW-1:0] snoop_di,
  input  logic          start,
  output logic          char_valid,
  output logic [7:0]    char_data,
  output logic [CW-1:0] char_chan,
  input  logic          char_ready,
  output logic          clr_req,
  output logic [AW-1:0] clr_addr,
  input  logic          clr_ack,
  output logic          sim_end,
  output logic [1:0]    end_cause,
  output logic [DW-1:0] end_code,
  output logic [CW-1:0] end_chan,
  output logic [7:0]    ovf_cnt
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  chan_st_e      chan_st  [NCH];
  logic [DW-1:0] chan_arg [NCH];
  logic [DW-1:0] chan_cmd [NCH];
  logic [NCH-1:0] arg_hit;
  logic [NCH-1:0] cmd_hit;
  logic           pend_any;
  logic [CW-1:0]  pend_idx;

  disp_st_e       disp_st;
  logic [CW-1:0]  gnt;
  logic [DW-1:0]  cur_arg;
  logic [DW-1:0]  cur_cmd;
  logic           exec_exit;
  logic           exec_putc;

  logic [CW+7:0]  fifo_head;
  logic           fifo_full;
  logic           fifo_empty;

  logic           wd_run;
  logic [WDW-1:0] wd_cnt;
  logic           wd_hit;

  // Address decode: at most one mailbox word matches any snoop write.
  always_comb begin
    arg_hit = '0;
    cmd_hit = '0;
    for (int c = 0; c < NCH; c++) begin
      arg_hit[c] = snoop_cs && snoop_we && (snoop_a == TOHOST_BASE + AW'(2 * c));
      cmd_hit[c] = snoop_cs && snoop_we && (snoop_a == TOHOST_BASE + AW'(2 * c + 1));
    end
  end

  // Fixed-priority arbiter: lowest-index pending channel wins.
  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (chan_st[c] == CH_PEND) begin
        pend_any = 1'b1;
        pend_idx = CW'(c);
      end
    end
  end

  // Per-channel mailbox capture; a pending channel ignores the bus until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        chan_st[c]  <= CH_EMPTY;
        chan_arg[c] <= '0;
        chan_cmd[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (disp_st == D_CLR_CMD && clr_ack && gnt == CW'(c)) begin
          chan_st[c] <= CH_EMPTY;
        end else begin
          case (chan_st[c])
            CH_EMPTY: begin
              if (arg_hit[c]) begin
                chan_arg[c] <= snoop_di;
                chan_st[c]  <= CH_HAVE_ARG;
              end
            end
            CH_HAVE_ARG: begin
              if (arg_hit[c]) begin
                chan_arg[c] <= snoop_di;
              end else if (cmd_hit[c]) begin
                chan_cmd[c] <= snoop_di;
                chan_st[c]  <= CH_PEND;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign cur_arg   = chan_arg[gnt];
  assign cur_cmd   = chan_cmd[gnt];
  assign exec_exit = (disp_st == D_EXEC) && (cur_cmd == DW'(HTIF_CMD_EXIT));
  assign exec_putc = (disp_st == D_EXEC) && (cur_cmd == DW'(HTIF_CMD_PUTC));

  // Dispatch FSM: grant, execute, then clear arg and cmd words via injection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_st  <= D_IDLE;
      gnt      <= '0;
      clr_req  <= 1'b0;
      clr_addr <= '0;
    end else begin
      case (disp_st)
        D_IDLE: begin
          if (pend_any) begin
            gnt     <= pend_idx;
            disp_st <= D_EXEC;
          end
        end
        D_EXEC: begin
          clr_req  <= 1'b1;
          clr_addr <= TOHOST_BASE + AW'({gnt, 1'b0});
          disp_st  <= D_CLR_ARG;
        end
        D_CLR_ARG: begin
          if (clr_ack) begin
            clr_addr <= clr_addr + AW'(1);
            disp_st  <= D_CLR_CMD;
          end
        end
        default: begin
          if (clr_ack) begin
            clr_req  <= 1'b0;
            clr_addr <= '0;
            disp_st  <= D_IDLE;
          end
        end
      endcase
    end
  end

  htif_char_fifo #(
    .W     (CW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_char_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (exec_putc),
    .push_data ({gnt, cur_arg[7:0]}),
    .pop       (char_ready),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign char_valid = !fifo_empty;
  assign char_data  = char_valid ? fifo_head[7:0] : 8'h00;
  assign char_chan  = char_valid ? fifo_head[CW+7:8] : '0;

  // Dropped-character counter, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (exec_putc && fifo_full && !char_ready && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  assign wd_hit = (TIMEOUT != 0) && wd_run && !start && !sim_end &&
                  (wd_cnt == WDW'(TIMEOUT - 1));

  // Watchdog counter: start restarts from zero, counting stops once the test ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_run <= 1'b0;
      wd_cnt <= '0;
    end else if (start) begin
      wd_run <= 1'b1;
      wd_cnt <= '0;
    end else if (wd_run && !sim_end && TIMEOUT != 0) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky end-of-test; a command exit beats a watchdog expiry in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_end   <= 1'b0;
      end_cause <= END_NONE;
      end_code  <= '0;
      end_chan  <= '0;
    end else if (!sim_end) begin
      if (exec_exit) begin
        sim_end   <= 1'b1;
        end_cause <= END_EXIT;
        end_code  <= cur_arg;
        end_chan  <= gnt;
      end else if (wd_hit) begin
        sim_end   <= 1'b1;
        end_cause <= END_TIMEOUT;
        end_code  <= '0;
        end_chan  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_htif_mbox_mon.sv
// tb/tb_htif_mbox_mon.sv - directed self-checking bench for htif_mbox_mon
module tb_htif_mbox_mon;

  localparam logic [31:0] PUTC = 32'h0101_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        snoop_cs, snoop_we;
  logic [13:0] snoop_a;
  logic [31:0] snoop_di;
  logic        start;
  logic        char_valid;
  logic [7:0]  char_data;
  logic [0:0]  char_chan;
  logic        char_ready;
  logic        clr_req;
  logic [13:0] clr_addr;
  logic        clr_ack;
  logic        sim_end;
  logic [1:0]  end_cause;
  logic [31:0] end_code;
  logic [0:0]  end_chan;
  logic [7:0]  ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  htif_mbox_mon #(
    .NCH         (2),
    .AW          (14),
    .DW          (32),
    .TOHOST_BASE (14'h400),
    .FIFO_DEPTH  (8),
    .TIMEOUT     (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .snoop_cs   (snoop_cs),
    .snoop_we   (snoop_we),
    .snoop_a    (snoop_a),
    .snoop_di   (snoop_di),
    .start      (start),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_chan  (char_chan),
    .char_ready (char_ready),
    .clr_req    (clr_req),
    .clr_addr   (clr_addr),
    .clr_ack    (clr_ack),
    .sim_end    (sim_end),
    .end_cause  (end_cause),
    .end_code   (end_code),
    .end_chan   (end_chan),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    snoop_cs = 1'b1;
    snoop_we = 1'b1;
    snoop_a  = a;
    snoop_di = d;
    tick();
    snoop_cs = 1'b0;
    snoop_we = 1'b0;
  endtask

  task automatic putc(input int ch, input logic [7:0] b);
    wr(14'h400 + 14'(2 * ch), {24'h0, b});
    wr(14'h401 + 14'(2 * ch), PUTC);
  endtask

  task automatic pop1();
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sim_end"}, {31'h0, sim_end}, 0);
    chk({tag, "_cause"}, {30'h0, end_cause}, 0);
    chk({tag, "_code"}, end_code, 0);
    chk({tag, "_ovf"}, {24'h0, ovf_cnt}, 0);
    chk({tag, "_cvalid"}, {31'h0, char_valid}, 0);
    chk({tag, "_clr_req"}, {31'h0, clr_req}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; snoop_cs = 1'b0; snoop_we = 1'b0; snoop_a = '0; snoop_di = '0;
    start = 1'b0; char_ready = 1'b0; clr_ack = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_zero("reset");

    // ch0 putchar with clear sequence
    putc(0, 8'h41);
    chk("t1_req_T", {31'h0, clr_req}, 0);
    tick();
    chk("t1_cvalid_T1", {31'h0, char_valid}, 0);
    tick();
    chk("t1_cvalid", {31'h0, char_valid}, 1);
    chk("t1_cdata", {24'h0, char_data}, 32'h41);
    chk("t1_cchan", {31'h0, char_chan}, 0);
    chk("t1_req_arg", {31'h0, clr_req}, 1);
    chk("t1_addr_arg", {18'h0, clr_addr}, 32'h400);
    tick();
    chk("t1_req_cmd", {31'h0, clr_req}, 1);
    chk("t1_addr_cmd", {18'h0, clr_addr}, 32'h401);
    tick();
    chk("t1_req_done", {31'h0, clr_req}, 0);
    chk("t1_sim_end", {31'h0, sim_end}, 0);
    pop1();
    chk("t1_popped", {31'h0, char_valid}, 0);

    // ch1 exit
    wr(14'h402, 32'h1);
    wr(14'h403, 32'h0);
    tick();
    chk("t2_sim_end_T1", {31'h0, sim_end}, 0);
    tick();
    chk("t2_sim_end", {31'h0, sim_end}, 1);
    chk("t2_cause", {30'h0, end_cause}, 1);
    chk("t2_code", end_code, 1);
    chk("t2_chan", {31'h0, end_chan}, 1);
    tick(); tick();

    // two channels pending back to back
    wr(14'h400, 32'h61);
    wr(14'h402, 32'h62);
    wr(14'h401, PUTC);
    wr(14'h403, PUTC);
    repeat (8) tick();
    chk("t3_head0", {24'h0, char_data}, 32'h61);
    chk("t3_chan0", {31'h0, char_chan}, 0);
    pop1();
    chk("t3_head1", {24'h0, char_data}, 32'h62);
    chk("t3_chan1", {31'h0, char_chan}, 1);
    pop1();
    chk("t3_empty", {31'h0, char_valid}, 0);

    // overflow: ten characters into eight entries
    for (int i = 0; i < 10; i++) begin
      putc(0, 8'(8'h30 + i));
      repeat (4) tick();
    end
    chk("t4_ovf", {24'h0, ovf_cnt}, 2);
    chk("t4_head", {24'h0, char_data}, 32'h30);
    // push and pop on a full FIFO in the same cycle
    putc(0, 8'h3A);
    tick();
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    chk("t4_ovf_pushpop", {24'h0, ovf_cnt}, 2);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_drain%0d", i), {24'h0, char_data}, (i == 7) ? 32'h3A : 32'(8'h31 + i));
      pop1();
    end
    chk("t4_empty", {31'h0, char_valid}, 0);
    pop1();
    chk("t4_pop_empty", {31'h0, char_valid}, 0);

    // watchdog
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("t5_rst");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    chk("t5_sim_end_49", {31'h0, sim_end}, 0);
    tick();
    chk("t5_sim_end_50", {31'h0, sim_end}, 1);
    chk("t5_cause", {30'h0, end_cause}, 2);
    chk("t5_code", end_code, 0);
    chk("t5_chan", {31'h0, end_chan}, 0);
    wr(14'h402, 32'h7);
    wr(14'h403, 32'h0);
    repeat (4) tick();
    chk("t5_cause_sticky", {30'h0, end_cause}, 2);
    chk("t5_code_sticky", end_code, 0);

    // reset during a stalled clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr_ack = 1'b0;
    putc(0, 8'h55);
    tick(); tick();
    chk("t6_req", {31'h0, clr_req}, 1);
    chk("t6_addr", {18'h0, clr_addr}, 32'h400);
    repeat (3) tick();
    chk("t6_req_hold", {31'h0, clr_req}, 1);
    chk("t6_addr_hold", {18'h0, clr_addr}, 32'h400);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t6_async_rst");
    tick();
    rst = 1'b0;
    clr_ack = 1'b1;
    putc(0, 8'h5A);
    tick(); tick();
    chk("t6_cvalid", {31'h0, char_valid}, 1);
    chk("t6_cdata", {24'h0, char_data}, 32'h5A);
    chk("t6_cchan", {31'h0, char_chan}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
